// File: rtl/seq_emit_buffer.sv
// Sequence emit buffer: captures one lazy-summary result per done pulse into a
// first-word-fall-through FIFO and returns registered head/job feedback to the scheduler.

`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 16
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 16
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 16
`endif
`ifndef JOB_LEN_LOG2
`define JOB_LEN_LOG2 16
`endif

module seq_emit_buffer #(
  parameter int SEQ_LL_BITS     = `SEQ_LL_BITS,
  parameter int SEQ_ML_BITS     = `SEQ_ML_BITS,
  parameter int SEQ_OFFSET_BITS = `SEQ_OFFSET_BITS,
  parameter int JOB_LEN_LOG2    = `JOB_LEN_LOG2,
  parameter int DEPTH           = 16,
  parameter int AF_MARGIN       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_summary_done,
  input  logic [JOB_LEN_LOG2-1:0]     i_seq_head_ptr,
  input  logic [SEQ_LL_BITS-1:0]      i_summary_ll,
  input  logic [SEQ_ML_BITS-1:0]      i_summary_ml,
  input  logic [SEQ_OFFSET_BITS-1:0]  i_summary_offset,
  input  logic                        i_summary_delim,
  input  logic                        i_summary_eoj,
  input  logic [SEQ_ML_BITS-1:0]      i_summary_overlap_len,
  input  logic                        i_move_to_next_job,
  input  logic [JOB_LEN_LOG2-1:0]     i_move_forward,
  output logic                        o_seq_valid,
  input  logic                        i_seq_ready,
  output logic [SEQ_LL_BITS-1:0]      o_seq_ll,
  output logic [SEQ_ML_BITS-1:0]      o_seq_ml,
  output logic [SEQ_OFFSET_BITS-1:0]  o_seq_offset,
  output logic [SEQ_ML_BITS-1:0]      o_seq_overlap_len,
  output logic                        o_seq_eoj,
  output logic                        o_seq_delim,
  output logic                        o_head_update_valid,
  output logic [JOB_LEN_LOG2-1:0]     o_head_ptr,
  output logic                        o_job_advance,
  output logic [$clog2(DEPTH):0]      o_fifo_count,
  output logic                        o_almost_full,
  output logic                        o_overflow,
  output logic [15:0]                 o_jobs_emitted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);

  typedef struct packed {
    logic [SEQ_LL_BITS-1:0]     ll;
    logic [SEQ_ML_BITS-1:0]     ml;
    logic [SEQ_OFFSET_BITS-1:0] offset;
    logic [SEQ_ML_BITS-1:0]     overlap_len;
    logic                       eoj;
    logic                       delim;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;

  always_comb begin
    wr_entry             = '0;
    wr_entry.ll          = i_summary_ll;
    wr_entry.ml          = i_summary_ml;
    wr_entry.offset      = i_summary_offset;
    wr_entry.overlap_len = i_summary_overlap_len;
    wr_entry.eoj         = i_summary_eoj;
    wr_entry.delim       = i_summary_delim;

    head  = mem[rd_ptr];
    full  = (count == FULL_LEVEL);
    pop   = (count != '0) && i_seq_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push  = i_summary_done && (!full || pop);
    drop  = i_summary_done && full && !pop;

    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: storage is deliberately not reset; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      o_almost_full  <= 1'b0;
      o_overflow     <= 1'b0;
      o_jobs_emitted <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count         <= count_nxt;
      o_almost_full <= (count_nxt >= AF_LEVEL);
      if (drop) o_overflow <= 1'b1;
      if (pop && head.eoj) o_jobs_emitted <= o_jobs_emitted + 16'd1;
    end
  end

  // Scheduler feedback follows every summary, whether or not the entry was stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_head_update_valid <= 1'b0;
      o_head_ptr          <= '0;
      o_job_advance       <= 1'b0;
    end else begin
      o_head_update_valid <= i_summary_done;
      if (i_summary_done) begin
        o_job_advance <= i_move_to_next_job;
        o_head_ptr    <= i_move_to_next_job ? '0 : (i_seq_head_ptr + i_move_forward);
      end
    end
  end

  always_comb begin
    o_seq_valid       = (count != '0);
    o_fifo_count      = count;
    o_seq_ll          = o_seq_valid ? head.ll          : '0;
    o_seq_ml          = o_seq_valid ? head.ml          : '0;
    o_seq_offset      = o_seq_valid ? head.offset      : '0;
    o_seq_overlap_len = o_seq_valid ? head.overlap_len : '0;
    o_seq_eoj         = o_seq_valid && head.eoj;
    o_seq_delim       = o_seq_valid && head.delim;
  end

endmodule
